alu_rs_unit: RTL and testbench

- Parametrised successor to the single ALU: an integer ALU fronted by a DEPTH-entry reservation station.
- Accepts dispatched ops with ready or pending operands and captures pending operands from the CDB by tag.
- Issues the lowest-index fully-ready entry to a registered ALU stage, then broadcasts result plus ROB tag through a valid/ready handshake.
- Sits between dispatch/rename and the CDB arbiter.

---
 rtl/alu_rs_unit.sv | 151 +++++++++++++++
 tb/tb_alu_rs_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs_unit.sv
// alu_rs_unit: DEPTH-entry reservation station with CDB wakeup feeding a registered integer ALU.
// Optional ALU_RS_FLUSH_EN adds flush/flush_tag to squash entries younger than flush_tag.
module alu_rs_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int TAG_W = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [3:0]                   in_op,
    input  logic [TAG_W-1:0]             in_rob_tag,
    input  logic                         in_src1_rdy,
    input  logic                         in_src2_rdy,
    input  logic [WIDTH-1:0]             in_src1_val,
    input  logic [WIDTH-1:0]             in_src2_val,
    input  logic [TAG_W-1:0]             in_src1_tag,
    input  logic [TAG_W-1:0]             in_src2_tag,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [WIDTH-1:0]             cdb_val,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [TAG_W-1:0]             out_rob_tag,
    output logic [WIDTH-1:0]             out_result,
`ifdef ALU_RS_FLUSH_EN
    input  logic                         flush,
    input  logic [TAG_W-1:0]             flush_tag,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int IW = $clog2(DEPTH);
    localparam int SW = $clog2(WIDTH);
    localparam int OW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] r_vld, r_r1, r_r2;
    logic [3:0]       r_op  [DEPTH];
    logic [TAG_W-1:0] r_tag [DEPTH];
    logic [TAG_W-1:0] r_t1  [DEPTH];
    logic [TAG_W-1:0] r_t2  [DEPTH];
    logic [WIDTH-1:0] r_v1  [DEPTH];
    logic [WIDTH-1:0] r_v2  [DEPTH];

    logic [DEPTH-1:0] w_rdy, w_kill;
    logic [IW-1:0]    w_free_idx, w_iss_idx;
    logic             w_alloc, w_issue, w_flush, w_kill_out, w_kill_new, w_c1, w_c2;
    logic [WIDTH-1:0] w_a, w_b, w_res;
    logic [SW-1:0]    w_sh;

`ifdef ALU_RS_FLUSH_EN
    // Younger means a nonzero forward distance within half the tag ring.
    function automatic logic f_young(input logic [TAG_W-1:0] t);
        logic [TAG_W-1:0] d;
        d = t - flush_tag;
        return flush && (d != '0) && !d[TAG_W-1];
    endfunction
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_rdy     = r_vld & r_r1 & r_r2;
    assign in_ready  = (occupancy < OW'(DEPTH)) && !w_flush;
    assign w_alloc   = in_valid && in_ready;
    assign w_issue   = (!out_valid || out_ready) && (|w_rdy);
    assign w_c1      = cdb_valid && (cdb_tag == in_src1_tag);
    assign w_c2      = cdb_valid && (cdb_tag == in_src2_tag);
    assign w_a       = r_v1[w_iss_idx];
    assign w_b       = r_v2[w_iss_idx];
    assign w_sh      = w_b[SW-1:0];

    always_comb begin
        occupancy  = '0;
        w_free_idx = '0;
        w_iss_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            occupancy = occupancy + OW'(r_vld[i]);
            if (!r_vld[i]) w_free_idx = IW'(i);
            if (w_rdy[i]) w_iss_idx = IW'(i);
        end
    end

    always_comb begin
        w_kill     = '0;
        w_kill_out = 1'b0;
        w_kill_new = 1'b0;
`ifdef ALU_RS_FLUSH_EN
        for (int i = 0; i < DEPTH; i++) w_kill[i] = f_young(r_tag[i]);
        w_kill_out = f_young(out_rob_tag);
        w_kill_new = f_young(r_tag[w_iss_idx]);
`endif
    end

    always_comb begin
        w_res = '0;
        case (r_op[w_iss_idx])
            4'd0: w_res = w_a + w_b;
            4'd1: w_res = w_a - w_b;
            4'd2: w_res = w_a & w_b;
            4'd3: w_res = w_a | w_b;
            4'd4: w_res = w_a ^ w_b;
            4'd5: w_res = w_a << w_sh;
            4'd6: w_res = w_a >> w_sh;
            4'd7: w_res = $signed(w_a) >>> w_sh;
            4'd8: w_res = {{(WIDTH-1){1'b0}}, $signed(w_a) < $signed(w_b)};
            4'd9: w_res = {{(WIDTH-1){1'b0}}, w_a < w_b};
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld       <= '0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_rob_tag <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cdb_valid && r_vld[i] && !r_r1[i] && cdb_tag == r_t1[i]) begin
                    r_r1[i] <= 1'b1;
                    r_v1[i] <= cdb_val;
                end
                if (cdb_valid && r_vld[i] && !r_r2[i] && cdb_tag == r_t2[i]) begin
                    r_r2[i] <= 1'b1;
                    r_v2[i] <= cdb_val;
                end
            end
            if (w_issue) r_vld[w_iss_idx] <= 1'b0;
            if (w_alloc) begin
                r_vld[w_free_idx] <= 1'b1;
                r_op[w_free_idx]  <= in_op;
                r_tag[w_free_idx] <= in_rob_tag;
                r_t1[w_free_idx]  <= in_src1_tag;
                r_t2[w_free_idx]  <= in_src2_tag;
                r_r1[w_free_idx]  <= in_src1_rdy || w_c1;
                r_r2[w_free_idx]  <= in_src2_rdy || w_c2;
                r_v1[w_free_idx]  <= in_src1_rdy ? in_src1_val : cdb_val;
                r_v2[w_free_idx]  <= in_src2_rdy ? in_src2_val : cdb_val;
            end
            for (int i = 0; i < DEPTH; i++) if (w_kill[i]) r_vld[i] <= 1'b0;
            if (w_issue && !w_kill_new) begin
                out_valid   <= 1'b1;
                out_result  <= w_res;
                out_rob_tag <= r_tag[w_iss_idx];
            end else if (w_issue || out_ready || w_kill_out) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_rs_unit.sv
// tb_alu_rs_unit: scoreboard bench for alu_rs_unit with default parameters (flush feature off).
module tb_alu_rs_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rob_tag, in_src1_tag, in_src2_tag;
    logic        in_src1_rdy, in_src2_rdy;
    logic [31:0] in_src1_val, in_src2_val;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_val;
    logic        out_valid, out_ready;
    logic [4:0]  out_rob_tag;
    logic [31:0] out_result;
    logic [3:0]  occupancy;

    int          n_chk = 0;
    int          n_err = 0;
    logic [63:0] sb [$];
    logic [63:0] sb_e;

    alu_rs_unit dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rob_tag(in_rob_tag), .in_src1_rdy(in_src1_rdy), .in_src2_rdy(in_src2_rdy),
        .in_src1_val(in_src1_val), .in_src2_val(in_src2_val), .in_src1_tag(in_src1_tag),
        .in_src2_tag(in_src2_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_rob_tag(out_rob_tag),
        .out_result(out_result), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [3:0] op, input logic [4:0] tag,
                        input logic r1, input logic [31:0] v1, input logic [4:0] t1,
                        input logic r2, input logic [31:0] v2, input logic [4:0] t2,
                        input logic [31:0] exp, input bit push);
        in_valid = 1'b1; in_op = op; in_rob_tag = tag;
        in_src1_rdy = r1; in_src1_val = v1; in_src1_tag = t1;
        in_src2_rdy = r2; in_src2_val = v2; in_src2_tag = t2;
        if (push) sb.push_back({27'd0, tag, exp});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic bcast(input logic [4:0] tag, input logic [31:0] val);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_val = val;
        tick();
        cdb_valid = 1'b0;
    endtask

    // Every accepted result is compared against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) chk("sb_underflow", {27'd0, out_rob_tag, out_result}, 64'hdead);
            else begin
                sb_e = sb.pop_front();
                chk("result", {27'd0, out_rob_tag, out_result}, sb_e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  ops [12];
        logic [31:0] as  [12];
        logic [31:0] bs  [12];
        logic [31:0] exs [12];
        logic [31:0] fb  [8];
        logic [31:0] fe  [8];
        logic [31:0] held;
        ops = '{4'd7, 4'd8, 4'd9, 4'd5, 4'd6, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd12, 4'd8};
        as  = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h80000000, 32'hFFFFFFFF,
                32'h0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h1234, 32'h5};
        bs  = '{32'h4, 32'h1, 32'h1, 32'd33, 32'd31, 32'h1,
                32'h1, 32'h0FF00FF0, 32'h0F0F0F0F, 32'h0FF00FF0, 32'h1, 32'h3};
        exs = '{32'hF8000000, 32'h1, 32'h0, 32'h2, 32'h1, 32'h0,
                32'hFFFFFFFF, 32'h00F000F0, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'h0, 32'h0};
        fb  = '{32'h1, 32'h2, 32'h1F0, 32'h3, 32'h101, 32'h4, 32'h8, 32'h1};
        fe  = '{32'h101, 32'hFE, 32'h100, 32'h103, 32'h1, 32'h1000, 32'h1, 32'h80};
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rob_tag = '0;
        in_src1_rdy = 1'b0; in_src2_rdy = 1'b0; in_src1_val = '0; in_src2_val = '0;
        in_src1_tag = '0; in_src2_tag = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_val = '0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_result", out_result, 0);
        chk("rst_tag", out_rob_tag, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();

        disp(4'd0, 5'd3, 1, 32'd5, 5'd0, 1, 32'd7, 5'd0, 32'd12, 1);
        chk("add_occ1", occupancy, 1);
        chk("add_not_yet", out_valid, 0);
        tick();
        chk("add_valid", out_valid, 1);
        chk("add_result", out_result, 12);
        chk("add_tag", out_rob_tag, 3);
        chk("add_occ0", occupancy, 0);
        tick();
        chk("add_drained", out_valid, 0);

        disp(4'd1, 5'd1, 0, 32'd0, 5'd9, 1, 32'd4, 5'd0, 32'd16, 1);
        chk("sub_occ", occupancy, 1);
        tick();
        chk("sub_wait1", out_valid, 0);
        tick();
        chk("sub_wait2", out_valid, 0);
        bcast(5'd9, 32'd20);
        chk("sub_wake_no_issue", out_valid, 0);
        tick();
        chk("sub_valid", out_valid, 1);
        chk("sub_result", out_result, 16);
        tick();

        for (int i = 0; i < 8; i++)
            disp(4'(i), 5'(10 + i), 0, 32'd0, 5'd1, 1, fb[i], 5'd0, fe[i], 1);
        chk("full_occ", occupancy, 8);
        chk("full_in_ready", in_ready, 0);
        bcast(5'd1, 32'h100);
        chk("full_wake_occ", occupancy, 8);
        chk("full_wake_ready", in_ready, 0);
        tick();
        chk("first_issue_occ", occupancy, 7);
        chk("first_issue_in_ready", in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", out_valid, 1);
            tick();
        end
        chk("drain_done", out_valid, 0);
        chk("drain_occ", occupancy, 0);

        out_ready = 1'b0;
        disp(4'd0, 5'd20, 1, 32'd100, 5'd0, 1, 32'd1, 5'd0, 32'd101, 1);
        tick();
        for (int i = 0; i < 3; i++)
            disp(4'd0, 5'(21 + i), 1, 32'(200 + i), 5'd0, 1, 32'd1, 5'd0, 32'(201 + i), 1);
        chk("bp_occ", occupancy, 3);
        held = out_result;
        chk("bp_held_val", held, 101);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_stable", out_result, 101);
            chk("bp_occ_hold", occupancy, 3);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_release_valid", out_valid, 1);
            tick();
        end
        chk("bp_release_done", out_valid, 0);

        for (int i = 0; i < 12; i++)
            disp(ops[i], 5'(i), 1, as[i], 5'd0, 1, bs[i], 5'd0, exs[i], 1);
        for (int i = 0; i < 20 && (out_valid || occupancy != 0); i++) tick();
        chk("ops_drained", occupancy, 0);

        cdb_valid = 1'b1; cdb_tag = 5'd6; cdb_val = 32'hAB;
        disp(4'd0, 5'd7, 0, 32'd0, 5'd6, 1, 32'd1, 5'd0, 32'hAC, 1);
        cdb_valid = 1'b0;
        tick();
        chk("capture_issue", out_valid, 1);
        chk("capture_result", out_result, 32'hAC);
        tick();

        disp(4'd0, 5'd8, 0, 32'd0, 5'd2, 0, 32'd0, 5'd2, 32'd10, 1);
        bcast(5'd2, 32'd5);
        tick();
        chk("dual_wake_valid", out_valid, 1);
        chk("dual_wake_result", out_result, 10);
        tick();

        out_ready = 1'b0;
        disp(4'd0, 5'd30, 1, 32'd1, 5'd0, 1, 32'd1, 5'd0, 32'd2, 0);
        disp(4'd0, 5'd31, 0, 32'd0, 5'd30, 1, 32'd1, 5'd0, 32'd0, 0);
        tick();
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        chk("mid_rst_occ", occupancy, 0);
        chk("mid_rst_valid", out_valid, 0);
        bcast(5'd30, 32'd9);
        tick();
        chk("post_rst_silent", out_valid, 0);
        tick();

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
